// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared video constants and frame-buffer FSM encodings
package video_pkg;

  localparam int H_RES        = 320;
  localparam int V_RES        = 240;
  localparam int DATA_WIDTH   = 12;
  localparam int FRAME_PIXELS = H_RES * V_RES;

  typedef enum logic {W_IDLE = 1'b0, W_FILL = 1'b1} wstate_t;
  typedef enum logic {R_IDLE = 1'b0, R_RUN  = 1'b1} rstate_t;

endpackage

// File: rtl/fb_bram.sv
// rtl/fb_bram.sv - simple dual-port inferred RAM, write port A, registered read port B
module fb_bram #(
  parameter int DATA_WIDTH = 12,
  parameter int DEPTH      = 32,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
    rdata_q <= mem[i_raddr];
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/frame_buffer_pingpong.sv
// rtl/frame_buffer_pingpong.sv - double-buffered frame store between capture stream and display FIFO
module frame_buffer_pingpong
  import video_pkg::*;
#(
  parameter int DATA_WIDTH   = video_pkg::DATA_WIDTH,
  parameter int FRAME_PIXELS = video_pkg::FRAME_PIXELS
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_flush,
  input  logic                  i_valid,
  input  logic                  i_sof,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_req,
  output logic                  o_wr,
  output logic [DATA_WIDTH-1:0] o_wdata,
  input  logic                  i_almostfull,
  output logic                  o_rbank,
  output logic                  o_short_frame,
  output logic                  o_frame_repeat
);

  localparam int ADDR_WIDTH = $clog2(FRAME_PIXELS);
  localparam int PA_WIDTH   = $clog2(2 * FRAME_PIXELS);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(FRAME_PIXELS - 1);

  function automatic logic [PA_WIDTH-1:0] phys(input logic bank, input logic [ADDR_WIDTH-1:0] a);
    return bank ? PA_WIDTH'(FRAME_PIXELS) + PA_WIDTH'(a) : PA_WIDTH'(a);
  endfunction

  wstate_t                 wstate_q;
  rstate_t                 rstate_q;
  logic [ADDR_WIDTH-1:0]   waddr_q, raddr_q;
  logic                    pending_q, pending_d, have_frame_q;
  logic                    rbank_q, wr_q, short_q, repeat_q;

  logic                    sof_px, w_we, w_last, r_issue, r_start, r_swap;
  logic [ADDR_WIDTH-1:0]   w_addr;

  assign sof_px  = i_valid & i_sof;
  assign w_we    = ~i_flush & (sof_px | (i_valid & (wstate_q == W_FILL)));
  assign w_addr  = sof_px ? '0 : waddr_q;
  assign w_last  = (wstate_q == W_FILL) & i_valid & ~i_sof & (waddr_q == LAST);
  assign r_issue = (rstate_q == R_RUN) & i_req & ~i_almostfull;
  // A frame restarting this cycle lands in the pending bank, so never hand it to the reader.
  assign r_start = (rstate_q == R_IDLE) & have_frame_q & pending_q & ~sof_px;
  assign r_swap  = r_issue & (raddr_q == LAST) & pending_q & ~sof_px;

  always_comb begin
    pending_d = pending_q;
    if (r_start || r_swap || sof_px) pending_d = 1'b0;
    if (w_last) pending_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wstate_q <= W_IDLE;
      waddr_q  <= '0;
      short_q  <= 1'b0;
    end else if (i_flush) begin
      wstate_q <= W_IDLE;
      waddr_q  <= '0;
      short_q  <= 1'b0;
    end else begin
      short_q <= 1'b0;
      case (wstate_q)
        W_IDLE: if (sof_px) begin
          waddr_q  <= ADDR_WIDTH'(1);
          wstate_q <= W_FILL;
        end
        W_FILL: if (sof_px) begin
          short_q <= 1'b1;
          waddr_q <= ADDR_WIDTH'(1);
        end else if (i_valid) begin
          if (waddr_q == LAST) begin
            waddr_q  <= '0;
            wstate_q <= W_IDLE;
          end else begin
            waddr_q <= waddr_q + ADDR_WIDTH'(1);
          end
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rstate_q     <= R_IDLE;
      raddr_q      <= '0;
      rbank_q      <= 1'b0;
      wr_q         <= 1'b0;
      repeat_q     <= 1'b0;
      pending_q    <= 1'b0;
      have_frame_q <= 1'b0;
    end else if (i_flush) begin
      rstate_q     <= R_IDLE;
      raddr_q      <= '0;
      rbank_q      <= 1'b0;
      wr_q         <= 1'b0;
      repeat_q     <= 1'b0;
      pending_q    <= 1'b0;
      have_frame_q <= 1'b0;
    end else begin
      wr_q      <= r_issue;
      repeat_q  <= 1'b0;
      pending_q <= pending_d;
      if (w_last) have_frame_q <= 1'b1;
      case (rstate_q)
        R_IDLE: if (r_start) begin
          rstate_q <= R_RUN;
          rbank_q  <= ~rbank_q;
          raddr_q  <= '0;
        end
        R_RUN: if (r_issue) begin
          if (raddr_q == LAST) begin
            raddr_q <= '0;
            if (r_swap) rbank_q  <= ~rbank_q;
            else        repeat_q <= 1'b1;
          end else begin
            raddr_q <= raddr_q + ADDR_WIDTH'(1);
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  fb_bram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (2 * FRAME_PIXELS),
    .AW         (PA_WIDTH)
  ) u_bram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (phys(~rbank_q, w_addr)),
    .i_wdata (i_data),
    .i_raddr (phys(rbank_q, raddr_q)),
    .o_rdata (o_wdata)
  );

  assign o_wr           = wr_q;
  assign o_rbank        = rbank_q;
  assign o_short_frame  = short_q;
  assign o_frame_repeat = repeat_q;

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// tb/tb_frame_buffer_pingpong.sv - scoreboard bench for frame_buffer_pingpong with 16-pixel frames
module tb_frame_buffer_pingpong;

  localparam int DW = 12;
  localparam int FP = 16;

  logic          clk = 1'b0;
  logic          rstn, flush, valid, sof, req, almostfull;
  logic [DW-1:0] data;
  logic          o_wr, o_rbank, o_short, o_repeat;
  logic [DW-1:0] o_wdata;

  int n_tests = 0;
  int n_fail  = 0;
  int rep_cnt = 0;
  int short_cnt = 0;
  int wr_cnt  = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  frame_buffer_pingpong #(.DATA_WIDTH(DW), .FRAME_PIXELS(FP)) dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_flush        (flush),
    .i_valid        (valid),
    .i_sof          (sof),
    .i_data         (data),
    .i_req          (req),
    .o_wr           (o_wr),
    .o_wdata        (o_wdata),
    .i_almostfull   (almostfull),
    .o_rbank        (o_rbank),
    .o_short_frame  (o_short),
    .o_frame_repeat (o_repeat)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (o_short) short_cnt++;
    if (o_repeat) rep_cnt++;
    if (o_wr) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_wr: got o_wr=1 data 0x%0h expected no write", o_wdata);
      end else begin
        chk("wdata", int'(o_wdata), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_frame(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      valid = 1'b1;
      sof   = (i == 0);
      data  = DW'(base + i);
      tick();
    end
    valid = 1'b0;
    sof   = 1'b0;
  endtask

  task automatic push_words(input int base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(DW'(base + i));
  endtask

  task automatic read_n(input int n);
    req = 1'b1;
    repeat (n) tick();
    req = 1'b0;
  endtask

  task automatic end_phase(input string tag, input int e_rbank, input int e_rep, input int e_short);
    repeat (3) tick();
    chk({tag, "_sb_empty"}, exp_q.size(), 0);
    chk({tag, "_rbank"}, int'(o_rbank), e_rbank);
    chk({tag, "_repeat_cnt"}, rep_cnt, e_rep);
    chk({tag, "_short_cnt"}, short_cnt, e_short);
    exp_q.delete();
  endtask

  task automatic idle_check(input string tag);
    int w0;
    w0 = wr_cnt;
    read_n(10);
    repeat (2) tick();
    chk({tag, "_idle_no_wr"}, wr_cnt - w0, 0);
  endtask

  initial begin
    int issued;
    int cyc;
    logic r, af;
    rstn = 1'b0; flush = 1'b0; valid = 1'b0; sof = 1'b0;
    data = '0; req = 1'b0; almostfull = 1'b0;
    repeat (3) tick();
    chk("reset_o_wr", int'(o_wr), 0);
    chk("reset_o_rbank", int'(o_rbank), 0);
    chk("reset_short", int'(o_short), 0);
    chk("reset_repeat", int'(o_repeat), 0);
    rstn = 1'b1;
    tick();

    // Frame A lands in bank 1 (writer bank is ~o_rbank), then one pass plus a repeat.
    write_frame(12'h000, FP);
    repeat (3) tick();
    push_words(12'h000, FP);
    req = 1'b1;
    @(negedge clk);
    chk("wr_latency_pre", int'(o_wr), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("wr_latency_post", int'(o_wr), 1);
    repeat (15) tick();
    req = 1'b0;
    end_phase("p1", 1, 1, 0);

    // Frame B completes in the same cycle as the reader EOF: repeat, A again, then swap to B.
    push_words(12'h000, FP);
    push_words(12'h000, FP);
    push_words(12'h100, FP);
    for (int i = 0; i < 3 * FP; i++) begin
      req   = 1'b1;
      valid = (i < FP);
      sof   = (i == 0);
      data  = DW'(12'h100 + i);
      tick();
    end
    req = 1'b0; valid = 1'b0; sof = 1'b0;
    end_phase("p2", 0, 3, 0);

    push_words(12'h100, FP);
    read_n(FP);
    end_phase("p3_repeat", 0, 4, 0);

    // Aborted frame after 5 pixels, then a full frame D; the partial frame must never show.
    write_frame(12'h200, 5);
    write_frame(12'h300, FP);
    tick();
    push_words(12'h100, FP);
    push_words(12'h300, FP);
    read_n(2 * FP);
    end_phase("p4_short", 1, 5, 1);

    // Backpressure and request gaps: D then E, exactly 32 issues.
    write_frame(12'h400, FP);
    tick();
    push_words(12'h300, FP);
    push_words(12'h400, FP);
    issued = 0;
    cyc = 0;
    while (issued < 2 * FP && cyc < 500) begin
      af = ((cyc / 3) % 2) == 1;
      r  = !(cyc >= 20 && cyc < 26);
      almostfull = af;
      req = r;
      tick();
      if (r && !af) issued++;
      cyc++;
    end
    req = 1'b0; almostfull = 1'b0;
    chk("p5_issue_budget", issued, 2 * FP);
    end_phase("p5_backpressure", 0, 6, 1);

    // Synchronous flush mid-read.
    push_words(12'h400, 7);
    req = 1'b1;
    repeat (7) tick();
    req = 1'b0;
    flush = 1'b1;
    tick();
    @(negedge clk);
    chk("flush_o_wr", int'(o_wr), 0);
    chk("flush_o_rbank", int'(o_rbank), 0);
    tick();
    flush = 1'b0;
    chk("flush_sb_empty", exp_q.size(), 0);
    idle_check("flush");
    write_frame(12'h500, FP);
    repeat (3) tick();
    push_words(12'h500, FP);
    read_n(FP);
    end_phase("p6_after_flush", 1, 7, 1);

    // Asynchronous reset mid-read while bank 1 is displayed; the 7th word is killed in flight.
    push_words(12'h500, 6);
    req = 1'b1;
    repeat (7) tick();
    #1;
    rstn = 1'b0;
    req  = 1'b0;
    #1;
    chk("areset_o_wr", int'(o_wr), 0);
    chk("areset_o_rbank", int'(o_rbank), 0);
    repeat (2) tick();
    rstn = 1'b1;
    chk("areset_sb_empty", exp_q.size(), 0);
    idle_check("areset");
    write_frame(12'h600, FP);
    repeat (3) tick();
    push_words(12'h600, FP);
    read_n(FP);
    end_phase("p7_after_reset", 1, 8, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
